pkg_sched: RTL and testbench
============================

# pkg_sched

Packet scheduler for the package layer. It decides which producer path (chip path or app path) may push its next packet into the shared package output. It issues fire/done handshakes to the path controllers and drives the output-mux select. Both paths are guarded by per-path enables and buffer-status urgency, and a microsecond watchdog aborts a path that never completes.

## Interface
- TMO_W, 16, width of watchdog timeout value (µs units)
- CNT_W, 16, width of completed-packet counter
- clk_sys  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- pluse_us  in  1  one-cycle pulse every microsecond
- cfg_en  in  2  [0] chip path enable, [1] app path enable
- cfg_prio  in  1  0 = round-robin, 1 = fixed priority (chip first)
- cfg_tmo  in  TMO_W  watchdog limit in µs; 0 disables the watchdog
- tmo_clr  in  1  clears tmo_err
- pcbuf_empty, pcbuf_full  in  1 each  chip buffer status
- pabuf_empty, pabuf_full  in  1 each  app buffer status
- fire_pchip  out  1  one-cycle start pulse to the chip path
- done_pchip  in  1  chip path completion (level-sampled)
- fire_papp  out  1  one-cycle start pulse to the app path
- done_papp  in  1  app path completion (level-sampled)
- mux_sel  out  1  0 = chip data to the output, 1 = app data
- busy  out  1  high outside IDLE
- tmo_err  out  1  sticky watchdog abort flag
- pkg_cnt  out  CNT_W  count of packets completed with done, wraps

## Operation
- Requests:
  - req_c = cfg_en[0] & ~pcbuf_empty
  - req_a = cfg_en[1] & ~pabuf_empty
  - urg_x = req_x & x_full
- Grant, evaluated only in IDLE:
  - If exactly one urg_x is set, grant that path.
  - Otherwise apply cfg_prio among the active requests. Round-robin means the grant goes to the path not equal to last-grant (lg). If only one path requests, grant it.
- FSM states: IDLE, FIRE, WAIT, GAP.
  - IDLE → FIRE when any request is set. Latch the grant into gsel; mux_sel <= gsel.
  - FIRE: fire_x = 1 for exactly this cycle. Clear the watchdog counter. → WAIT.
  - WAIT: sample done_x of the granted path.
    - done_x = 1 → GAP; pkg_cnt += 1.
    - Otherwise, if cfg_tmo ≠ 0 and the µs counter reaches cfg_tmo → GAP; tmo_err <= 1; pkg_cnt unchanged.
    - The µs counter increments only on pluse_us and saturates at its maximum.
  - GAP: lg <= gsel. → IDLE.
- mux_sel holds its value from IDLE→FIRE until the next grant. It does not revert in IDLE.
- Changes to cfg_en, cfg_prio or cfg_tmo take effect at the next IDLE evaluation. They do not affect a transaction in flight.
- done_x of the non-granted path is ignored.
- tmo_err: a set and tmo_clr in the same cycle leaves tmo_err = 1.

## Timing
- Reset values:
  - state = IDLE
  - fire_pchip = fire_papp = 0
  - mux_sel = 0
  - busy = 0
  - tmo_err = 0
  - pkg_cnt = 0
  - lg = app (so the chip path wins the first round-robin tie)
- All outputs are registered.
- Request seen in IDLE at cycle N → fire_x high in cycle N+1.
- WAIT occupies N+2 onward. done_x high at cycle M → GAP at M+1 → IDLE at M+2.
- With done held high, the minimum packet period is 4 cycles.
- Watchdog abort occurs in the cycle after the pluse_us that makes the counter equal cfg_tmo.
- Reset asserted mid-operation: immediate return to reset values. No fire pulse is emitted during or immediately after reset.

## Structure
- Shared define file pkg_def.v holds:
  - state encodings (IDLE=2'd0, FIRE=2'd1, WAIT=2'd2, GAP=2'd3)
  - path codes (PATH_CHIP=1'b0, PATH_APP=1'b1)
- One sub-module, pkg_tmo: µs watchdog counter.
  - Inputs: clk_sys, rst_n, clr, pluse_us, cfg_tmo.
  - Output: expire.
- Grant logic and FSM live in pkg_sched.

## Test plan
- Reset, then both buffers non-empty, cfg_en=2'b11, cfg_prio=0, done tied 1 → fires alternate chip, app, chip, app, 4 cycles apart; pkg_cnt=4 after four packets.
- cfg_prio=1, both requesting, done tied 1 → only fire_pchip while the chip buffer is non-empty; app is fired only once pcbuf_empty=1.
- Round-robin with lg=app but pabuf_full=1 and pcbuf not full → fire_papp granted; mux_sel=1 from the fire cycle on.
- cfg_tmo=3, done_pchip held 0 → after the third pluse_us in WAIT: tmo_err=1, return to IDLE, pkg_cnt unchanged. tmo_clr clears tmo_err, except on a cycle where a new abort also sets it.
- cfg_tmo=0, done held 0 for 1000 µs → stays in WAIT, tmo_err=0, busy=1.
- rst_n pulsed low during WAIT → all outputs return to reset values asynchronously. The next grant after release goes to chip.

Source files
------------

// File: rtl/pkg_sched_pkg.sv
// Shared types for the package-layer packet scheduler: FSM states and path codes.
package pkg_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_WAIT = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

   typedef enum logic {
      PATH_CHIP = 1'b0,
      PATH_APP  = 1'b1
   } path_e;

endpackage

// File: rtl/pkg_tmo.sv
// Microsecond watchdog: counts pluse_us ticks since the last clear, saturating,
// and flags expiry once the count reaches a non-zero limit.
module pkg_tmo #(
   parameter int unsigned TMO_W = 16
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             pluse_us,
   input  logic [TMO_W-1:0] cfg_tmo,
   output logic             expire
);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (pluse_us && (cnt_q != '1)) begin
         cnt_d = cnt_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A zero limit disables the watchdog entirely.
   assign expire = (cfg_tmo != '0) && (cnt_q >= cfg_tmo);

endmodule

// File: rtl/pkg_sched.sv
// Chip/app packet scheduler: urgency/priority/round-robin grant, fire/done
// handshake FSM, output-mux select and watchdog abort.
module pkg_sched
   import pkg_sched_pkg::*;
#(
   parameter int unsigned TMO_W = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             pluse_us,
   input  logic [1:0]       cfg_en,
   input  logic             cfg_prio,
   input  logic [TMO_W-1:0] cfg_tmo,
   input  logic             tmo_clr,
   input  logic             pcbuf_empty,
   input  logic             pcbuf_full,
   input  logic             pabuf_empty,
   input  logic             pabuf_full,
   output logic             fire_pchip,
   input  logic             done_pchip,
   output logic             fire_papp,
   input  logic             done_papp,
   output logic             mux_sel,
   output logic             busy,
   output logic             tmo_err,
   output logic [CNT_W-1:0] pkg_cnt
);

   state_e           state_q, state_d;
   path_e            gsel_q, gsel_d;
   path_e            lg_q, lg_d;
   path_e            grant;
   logic             fire_c_q, fire_c_d;
   logic             fire_a_q, fire_a_d;
   logic             busy_q, busy_d;
   logic             tmo_err_q, tmo_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0] tmo_lim_q, tmo_lim_d;
   logic             req_c, req_a, urg_c, urg_a;
   logic             done_g, tmo_set, expire;

   assign req_c = cfg_en[0] & ~pcbuf_empty;
   assign req_a = cfg_en[1] & ~pabuf_empty;
   assign urg_c = req_c & pcbuf_full;
   assign urg_a = req_a & pabuf_full;

   // A lone urgent path wins outright; otherwise priority or round-robin.
   always_comb begin
      grant = PATH_CHIP;
      if (urg_c != urg_a) begin
         if (urg_a) grant = PATH_APP;
      end else if (req_c && req_a) begin
         if (!cfg_prio && (lg_q == PATH_CHIP)) grant = PATH_APP;
      end else if (req_a) begin
         grant = PATH_APP;
      end
   end

   assign done_g = (gsel_q == PATH_APP) ? done_papp : done_pchip;

   always_comb begin
      state_d   = state_q;
      gsel_d    = gsel_q;
      lg_d      = lg_q;
      fire_c_d  = 1'b0;
      fire_a_d  = 1'b0;
      cnt_d     = cnt_q;
      tmo_lim_d = tmo_lim_q;
      tmo_set   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_c || req_a) begin
               state_d   = ST_FIRE;
               gsel_d    = grant;
               tmo_lim_d = cfg_tmo;
               fire_c_d  = (grant == PATH_CHIP);
               fire_a_d  = (grant == PATH_APP);
            end
         end
         ST_FIRE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (done_g) begin
               state_d = ST_GAP;
               cnt_d   = cnt_q + CNT_W'(1);
            end else if (expire) begin
               state_d = ST_GAP;
               tmo_set = 1'b1;
            end
         end
         ST_GAP: begin
            lg_d    = gsel_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d    = (state_d != ST_IDLE);
      tmo_err_d = tmo_set | (tmo_err_q & ~tmo_clr);
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         gsel_q    <= PATH_CHIP;
         lg_q      <= PATH_APP;
         fire_c_q  <= 1'b0;
         fire_a_q  <= 1'b0;
         busy_q    <= 1'b0;
         tmo_err_q <= 1'b0;
         cnt_q     <= '0;
         tmo_lim_q <= '0;
      end else begin
         state_q   <= state_d;
         gsel_q    <= gsel_d;
         lg_q      <= lg_d;
         fire_c_q  <= fire_c_d;
         fire_a_q  <= fire_a_d;
         busy_q    <= busy_d;
         tmo_err_q <= tmo_err_d;
         cnt_q     <= cnt_d;
         tmo_lim_q <= tmo_lim_d;
      end
   end

   // Limit is captured at grant so a cfg_tmo change cannot hit a packet in flight.
   pkg_tmo #(
      .TMO_W (TMO_W)
   ) u_tmo (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .clr      (state_q == ST_FIRE),
      .pluse_us (pluse_us),
      .cfg_tmo  (tmo_lim_q),
      .expire   (expire)
   );

   assign fire_pchip = fire_c_q;
   assign fire_papp  = fire_a_q;
   assign mux_sel    = gsel_q;
   assign busy       = busy_q;
   assign tmo_err    = tmo_err_q;
   assign pkg_cnt    = cnt_q;

endmodule

// File: tb/tb_pkg_sched.sv
// Directed bench for pkg_sched: round-robin, priority, urgency, watchdog and reset.
module tb_pkg_sched;

   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic        pluse_us;
   logic [1:0]  cfg_en;
   logic        cfg_prio;
   logic [15:0] cfg_tmo;
   logic        tmo_clr;
   logic        pcbuf_empty, pcbuf_full, pabuf_empty, pabuf_full;
   logic        fire_pchip, done_pchip, fire_papp, done_papp;
   logic        mux_sel, busy, tmo_err;
   logic [15:0] pkg_cnt;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   pkg_sched #(
      .TMO_W (16),
      .CNT_W (16)
   ) dut (
      .clk_sys     (clk_sys),
      .rst_n       (rst_n),
      .pluse_us    (pluse_us),
      .cfg_en      (cfg_en),
      .cfg_prio    (cfg_prio),
      .cfg_tmo     (cfg_tmo),
      .tmo_clr     (tmo_clr),
      .pcbuf_empty (pcbuf_empty),
      .pcbuf_full  (pcbuf_full),
      .pabuf_empty (pabuf_empty),
      .pabuf_full  (pabuf_full),
      .fire_pchip  (fire_pchip),
      .done_pchip  (done_pchip),
      .fire_papp   (fire_papp),
      .done_papp   (done_papp),
      .mux_sel     (mux_sel),
      .busy        (busy),
      .tmo_err     (tmo_err),
      .pkg_cnt     (pkg_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle_inputs();
      pluse_us    = 1'b0;
      cfg_en      = 2'b00;
      cfg_prio    = 1'b0;
      cfg_tmo     = '0;
      tmo_clr     = 1'b0;
      pcbuf_empty = 1'b1;
      pcbuf_full  = 1'b0;
      pabuf_empty = 1'b1;
      pabuf_full  = 1'b0;
      done_pchip  = 1'b0;
      done_papp   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic us_pulse();
      pluse_us = 1'b1;
      tick();
      pluse_us = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      #1;
      tick();
      tick();
      check("rst_fire_c", fire_pchip, 0);
      check("rst_fire_a", fire_papp, 0);
      check("rst_mux",    mux_sel, 0);
      check("rst_busy",   busy, 0);
      check("rst_tmo",    tmo_err, 0);
      check("rst_cnt",    pkg_cnt, 0);
      rst_n = 1'b1;

      // Round-robin, both paths, done tied high: chip, app, chip, app every 4 cycles.
      cfg_en = 2'b11; pcbuf_empty = 1'b0; pabuf_empty = 1'b0;
      done_pchip = 1'b1; done_papp = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         check("rr_fire_c", fire_pchip, (c % 8) == 1);
         check("rr_fire_a", fire_papp, (c % 8) == 5);
         check("rr_mux",    mux_sel, ((c - 1) / 4) % 2);
         check("rr_cnt",    pkg_cnt, (c + 1) / 4);
         check("rr_busy",   busy, (c % 4) != 0);
      end

      // Fixed priority: chip only until its buffer empties.
      cfg_prio = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         check("pr_fire_c", fire_pchip, (c % 4) == 1);
         check("pr_fire_a", fire_papp, 0);
      end
      pcbuf_empty = 1'b1;
      tick();
      check("pr_app_fire", fire_papp, 1);
      check("pr_app_chip", fire_pchip, 0);
      check("pr_app_mux",  mux_sel, 1);
      cfg_en = 2'b00;
      tick();
      tick();
      check("pr_cnt", pkg_cnt, 8);
      tick();
      check("pr_idle", busy, 0);

      // Urgency overrides round-robin: lg=app after reset, yet app is full.
      do_reset();
      check("urg_mux0", mux_sel, 0);
      cfg_en = 2'b11; pcbuf_empty = 1'b0; pabuf_empty = 1'b0; pabuf_full = 1'b1;
      done_pchip = 1'b1; done_papp = 1'b1;
      tick();
      check("urg_fire_a", fire_papp, 1);
      check("urg_fire_c", fire_pchip, 0);
      check("urg_mux",    mux_sel, 1);
      cfg_en = 2'b00; pabuf_full = 1'b0;
      tick(); tick(); tick();
      check("urg_cnt",      pkg_cnt, 1);
      check("urg_busy",     busy, 0);
      check("urg_mux_hold", mux_sel, 1);

      // Watchdog abort after 3 us with chip done low; app done is ignored.
      cfg_tmo = 16'd3; cfg_en = 2'b01; pcbuf_empty = 1'b0;
      done_pchip = 1'b0; done_papp = 1'b1;
      tick();
      check("wd_fire", fire_pchip, 1);
      cfg_en = 2'b00; cfg_tmo = 16'd0;
      tick();
      us_pulse(); tick();
      us_pulse(); tick();
      check("wd_pre_busy", busy, 1);
      check("wd_pre_err",  tmo_err, 0);
      us_pulse();
      check("wd_p3_busy", busy, 1);
      check("wd_p3_err",  tmo_err, 0);
      tick();
      check("wd_err",  tmo_err, 1);
      check("wd_cnt",  pkg_cnt, 1);
      tick();
      check("wd_idle", busy, 0);
      tmo_clr = 1'b1;
      tick();
      check("wd_clr", tmo_err, 0);
      tmo_clr = 1'b0;

      // Abort and clear in the same cycle: set wins.
      cfg_tmo = 16'd3; cfg_en = 2'b01;
      tick();
      cfg_en = 2'b00;
      tick();
      us_pulse(); tick();
      us_pulse(); tick();
      us_pulse();
      tmo_clr = 1'b1;
      tick();
      check("wd_set_clr", tmo_err, 1);
      tick();
      check("wd_clr2", tmo_err, 0);
      tmo_clr = 1'b0;

      // Watchdog disabled: 1000 us in WAIT without abort.
      cfg_tmo = 16'd0; cfg_en = 2'b01;
      tick();
      cfg_en = 2'b00;
      tick();
      for (int i = 0; i < 1000; i++) begin
         us_pulse();
         tick();
      end
      check("nowd_busy", busy, 1);
      check("nowd_err",  tmo_err, 0);
      check("nowd_cnt",  pkg_cnt, 1);

      // Asynchronous reset mid-WAIT; lg was chip, so reset must restore it to app.
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_cnt",  pkg_cnt, 0);
      check("arst_mux",  mux_sel, 0);
      check("arst_fire", fire_pchip | fire_papp, 0);
      tick();
      check("arst_hold_fire", fire_pchip | fire_papp, 0);
      idle_inputs();
      rst_n = 1'b1;
      tick();
      check("post_rst_fire", fire_pchip | fire_papp, 0);
      cfg_en = 2'b11; pcbuf_empty = 1'b0; pabuf_empty = 1'b0;
      done_pchip = 1'b1; done_papp = 1'b1;
      tick();
      check("post_rst_chip", fire_pchip, 1);
      check("post_rst_app",  fire_papp, 0);
      cfg_en = 2'b00;
      tick(); tick(); tick();
      check("post_rst_cnt", pkg_cnt, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
